// File: rtl/fp_add_pipe_if.sv
// Operand/result bundle for the pipelined FP add/subtract core.
// Core uses the slave modport; the operand producer / result consumer uses master.
interface fp_add_pipe_if #(
    parameter int EW = 11,
    parameter int FW = 52
);
    // Operand side
    logic          in_valid;
    logic          in_ready;
    logic [FW:0]   fa;
    logic [FW:0]   fb;
    logic [EW-1:0] ea;
    logic [EW-1:0] eb;
    logic          sa;
    logic          sb;
    logic          sub;
    logic [3:0]    fla;
    logic [3:0]    flb;
    logic [FW:0]   nan;
    logic [1:0]    RM;

    // Result side
    logic          out_valid;
    logic          out_ready;
    logic [EW-1:0] es;
    logic [FW+4:0] fs;
    logic          ss;
    logic [3:0]    fls;
    logic [FW:0]   nan_out;

    modport master (
        output in_valid, fa, fb, ea, eb, sa, sb, sub, fla, flb, nan, RM, out_ready,
        input  in_ready, out_valid, es, fs, ss, fls, nan_out
    );

    modport slave (
        input  in_valid, fa, fb, ea, eb, sa, sb, sub, fla, flb, nan, RM, out_ready,
        output in_ready, out_valid, es, fs, ss, fls, nan_out
    );
endinterface

// File: rtl/fp_add_pipe.sv
// 3-stage pipelined floating-point add/subtract on unpacked operands.
// S1 aligns the smaller operand, S2 adds/subtracts significands, S3 resolves
// sign and special-case flags. Result is unrounded (integer bits, fraction,
// guard/round/sticky) for a downstream normalise/round stage.
module fp_add_pipe #(
    parameter int EW = 11,
    parameter int FW = 52
) (
    input logic           clk,
    input logic           rst,
    fp_add_pipe_if.slave  bus
);
    // Aligned significand width: hidden bit + fraction + guard/round/sticky
    localparam int          SW   = FW + 4;
    localparam logic [SW-1:0] ONES = '1;

    logic advance;

    // S1 combinational alignment signals
    logic          sbe;
    logic          swap;
    logic [EW:0]   d;
    logic [EW-1:0] e_max;
    logic [FW:0]   f_lg;
    logic [FW:0]   f_sm;
    logic          s_lg;
    logic          s_sm;
    logic [SW-1:0] sm_ext;
    logic [SW-1:0] sm_shift;
    logic          sm_sticky;

    // S1 registers
    logic          v1;
    logic [EW-1:0] es1;
    logic [SW-1:0] lg1;
    logic [SW-1:0] sm1;
    logic          sl1;
    logic          ssm1;
    logic          sa1;
    logic          sbe1;
    logic [2:0]    fla1;
    logic [2:0]    flb1;
    logic [FW:0]   nan1;
    logic [1:0]    rm1;

    // S2 combinational add signals
    logic [SW:0]   raw_sum;
    logic [SW:0]   mag;
    logic          neg;
    logic          ss_tent;

    // S2 registers
    logic          v2;
    logic [EW-1:0] es2;
    logic [SW:0]   sum2;
    logic          ss2;
    logic          fszero2;
    logic          sa2;
    logic          sbe2;
    logic [2:0]    fla2;
    logic [2:0]    flb2;
    logic [FW:0]   nan2;
    logic [1:0]    rm2;

    // S3 combinational flag/sign signals
    logic inv;
    logic nans;
    logic infs;
    logic zero;
    logic ss_sel;

    // Operand ZERO flags are not needed: zero results come from the sum itself
    logic unused_zero_flags;
    assign unused_zero_flags = &{1'b0, bus.fla[3], bus.flb[3]};

    // Whole pipe shifts together unless the output register is full and blocked
    always_comb begin
        advance      = !bus.out_valid || bus.out_ready;
        bus.in_ready = advance;
    end

    // S1: pick the larger-exponent operand and right-shift the other with sticky
    always_comb begin
        sbe  = bus.sb ^ bus.sub;
        swap = bus.ea < bus.eb;
        if (swap) begin
            f_lg  = bus.fb;
            f_sm  = bus.fa;
            s_lg  = sbe;
            s_sm  = bus.sa;
            e_max = bus.eb;
            d     = {1'b0, bus.eb} - {1'b0, bus.ea};
        end else begin
            f_lg  = bus.fa;
            f_sm  = bus.fb;
            s_lg  = bus.sa;
            s_sm  = sbe;
            e_max = bus.ea;
            d     = {1'b0, bus.ea} - {1'b0, bus.eb};
        end
        sm_ext = {f_sm, 3'b000};
        if (32'(d) >= 32'(SW)) begin
            sm_shift  = '0;
            sm_sticky = |f_sm;
        end else begin
            sm_shift  = sm_ext >> d;
            sm_sticky = |(sm_ext & ~(ONES << d));
        end
    end

    // S1 register stage
    always_ff @(posedge clk) begin
        if (rst) begin
            v1   <= 1'b0;
            es1  <= '0;
            lg1  <= '0;
            sm1  <= '0;
            sl1  <= 1'b0;
            ssm1 <= 1'b0;
            sa1  <= 1'b0;
            sbe1 <= 1'b0;
            fla1 <= '0;
            flb1 <= '0;
            nan1 <= '0;
            rm1  <= '0;
        end else if (advance) begin
            v1   <= bus.in_valid;
            es1  <= e_max;
            lg1  <= {f_lg, 3'b000};
            sm1  <= {sm_shift[SW-1:1], sm_shift[0] | sm_sticky};
            sl1  <= s_lg;
            ssm1 <= s_sm;
            sa1  <= bus.sa;
            sbe1 <= sbe;
            fla1 <= bus.fla[2:0];
            flb1 <= bus.flb[2:0];
            nan1 <= bus.nan;
            rm1  <= bus.RM;
        end
    end

    // S2: signed significand add; a negative difference is negated and flips the sign
    always_comb begin
        if (sl1 != ssm1) begin
            raw_sum = {1'b0, lg1} - {1'b0, sm1};
        end else begin
            raw_sum = {1'b0, lg1} + {1'b0, sm1};
        end
        neg     = (sl1 != ssm1) && raw_sum[SW];
        mag     = neg ? (~raw_sum + 1'b1) : raw_sum;
        ss_tent = sl1 ^ neg;
    end

    // S2 register stage
    always_ff @(posedge clk) begin
        if (rst) begin
            v2      <= 1'b0;
            es2     <= '0;
            sum2    <= '0;
            ss2     <= 1'b0;
            fszero2 <= 1'b0;
            sa2     <= 1'b0;
            sbe2    <= 1'b0;
            fla2    <= '0;
            flb2    <= '0;
            nan2    <= '0;
            rm2     <= '0;
        end else if (advance) begin
            v2      <= v1;
            es2     <= es1;
            sum2    <= mag;
            ss2     <= ss_tent;
            fszero2 <= (mag == '0);
            sa2     <= sa1;
            sbe2    <= sbe1;
            fla2    <= fla1;
            flb2    <= flb1;
            nan2    <= nan1;
            rm2     <= rm1;
        end
    end

    // S3: special-case flags and final sign selection
    always_comb begin
        inv  = fla2[1] | flb2[1] | (fla2[2] & flb2[2] & (sa2 != sbe2));
        nans = fla2[0] | flb2[0] | inv;
        infs = (fla2[2] | flb2[2]) & !nans;
        zero = fszero2 & !infs & !nans;
        if (nans) begin
            ss_sel = 1'b0;
        end else if (infs) begin
            ss_sel = fla2[2] ? sa2 : sbe2;
        end else if (zero) begin
            ss_sel = (sa2 == sbe2) ? sa2 : (rm2 == 2'b11);
        end else begin
            ss_sel = ss2;
        end
    end

    // Output register stage; holds while the consumer stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.es        <= '0;
            bus.fs        <= '0;
            bus.ss        <= 1'b0;
            bus.fls       <= '0;
            bus.nan_out   <= '0;
        end else if (advance) begin
            bus.out_valid <= v2;
            bus.es        <= es2;
            bus.fs        <= sum2;
            bus.ss        <= ss_sel;
            bus.fls       <= {zero, inv, infs, nans};
            bus.nan_out   <= nan2;
        end
    end
endmodule
